alu_operand_sequencer: RTL
==========================

// Module: alu_operand_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 8-bit A/B register + ALU datapath. Accepts one 8-bit
//  instruction per valid/ready handshake and drives the ALU operand muxes, the ALU op and
//  the A/B register load enables. Operand encoding is 00=regA, 01=regB, 10=zero (0x00) and
//  11=one (0xFF). SWAP is sequenced as three XOR steps. Sits between instruction source and datapath.
// PARAMETERS
//  none; widths fixed: instr 8, sel 2, alu_op 3
// PORTS
//  clk          in   1  clock; all state changes on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  instr_valid  in   1  instr is valid; held with instr stable until accepted
//  instr        in   8  [7:4] opcode, [3] dst (0=A, 1=B), [2:0] ignored
//  instr_ready  out  1  block can accept; handshake = instr_valid & instr_ready
//  alu_zero     in   1  ALU result == 0 (combinational from datapath)
//  sel_a        out  2  ALU port-A operand select
//  sel_b        out  2  ALU port-B operand select (same encoding)
//  alu_op       out  3  000 ADD, 001 SUB(a-b), 010 AND, 011 OR, 100 XOR
//  load_a       out  1  write ALU result into regA at this edge
//  load_b       out  1  write ALU result into regB at this edge
//  busy         out  1  executing (state != IDLE)
//  done         out  1  1-cycle pulse in final execute cycle of each instruction
//  err          out  1  1-cycle pulse for illegal opcode (with done)
//  flag_z       out  1  registered zero flag of last writing instruction
// BEHAVIOUR
//  - States IDLE, EXEC, SWAP1, SWAP2. Outputs decoded from state + latched instr (no instr->out path).
//  - Reset (async, immediate): state IDLE; instr_ready=1, sel_a=sel_b=10, alu_op=000,
//    load_a=load_b=busy=done=err=0, flag_z=0. Reset mid-instruction aborts it; no further loads.
//  - IDLE: instr_ready=1, outputs as reset values. Handshake latches instr; -> EXEC (opcode C: -> SWAP1).
//  - EXEC: one cycle; load on dst per table; done=1; -> IDLE. Latency handshake->load = 1 cycle.
//  - SWAP1: A<=A^B (load_a) -> SWAP2: B<=A^B (load_b) -> EXEC: A<=A^B (load_a, done) -> IDLE.
//    SWAP steps: sel_a=00, sel_b=01, alu_op=XOR. instr_ready=0 in all non-IDLE states.
//  - Opcode table (D = dst reg code 00/01, O = other reg):
//    0 NOP: no load.   1 MOV: sel_a=O, sel_b=10, ADD.   2 CLR: 10,10, ADD.   3 SET: 11,10, ADD.
//    4 ADD/5 SUB/6 AND/7 OR/8 XOR: sel_a=00, sel_b=01.   9 NOT: D,11, XOR.
//    A DEC: D,11, ADD (D+0xFF).   B INC: D,11, SUB (D-0xFF = D+1 mod 256).   C SWAP (dst ignored).
//    D-F illegal: EXEC with no load, err=1, done=1.
//  - Arithmetic mod 256; carry not tracked by this block.
//  - flag_z <= alu_zero on any edge where load_a|load_b; unchanged by NOP/illegal/SWAP1/SWAP2.
//  - instr_valid while busy: ignored, no latch; accepted on first IDLE cycle.
// CONFIGURATION
//  SEQ_PIPELINE_EN defined: instr_ready also 1 in final execute cycle (EXEC); handshake there
//    latches next instr and moves directly to EXEC/SWAP1, giving back-to-back single-cycle ops
//    (1 instr/cycle, done every cycle). busy=0 only in IDLE.
//  Not defined: instr_ready=1 only in IDLE; max throughput 1 instr / 2 cycles.
// TESTING
//  1 Reset: rst_n=0 mid-clock -> immediately ready=1, loads=0, sel_a=sel_b=10, done=0, flag_z=0.
//  2 instr=0x40 (ADD->A) accepted edge 0 -> cycle 1: sel_a=00 sel_b=01 op=000 load_a=1 done=1;
//    cycle 2 ready=1. Model A=0x12,B=0x34 -> A=0x46.
//  3 instr=0xC0 (SWAP), A=0x12,B=0x34 -> load_a,load_b,load_a over 3 cycles, op=100, done only
//    3rd cycle, ready=0 all 3 -> A=0x34, B=0x12.
//  4 instr=0xB8 (INC B), B=0xFF -> sel_a=01 sel_b=11 op=001 load_b=1; B=0x00, alu_zero=1 -> flag_z=1.
//  5 instr=0xE0 (illegal) -> err=1, done=1, load_a=load_b=0, flag_z unchanged; 0x00 (NOP) same, err=0.
//  6 rst_n low during SWAP2 -> load_b drops at once, IDLE; next 0x20 (CLR A) runs normally, A=0x00.
//    With SEQ_PIPELINE_EN: valid held with 0x40,0x48,0x10 -> done on 3 consecutive cycles.

Source files
------------

// File: rtl/alu_operand_sequencer_if.sv
// Instruction handshake bundle between an instruction source and
// alu_operand_sequencer.
//
//   instr_valid  source -> sequencer  instr is valid; held stable until accepted
//   instr        source -> sequencer  [7:4] opcode, [3] dst (0=A, 1=B), [2:0] unused
//   instr_ready  sequencer -> source  sequencer can accept this cycle
//
// The master modport is the instruction source, and the slave modport is the sequencer.
interface alu_operand_sequencer_if;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Multi-cycle control FSM for the 8-bit A/B register + ALU datapath. The block
// accepts one instruction per valid/ready handshake. It drives the ALU operand
// selects, the ALU op and the A/B register load enables. It also keeps a
// registered zero flag for the last instruction that wrote a register.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_if        slave modport of alu_operand_sequencer_if (valid/instr/ready)
//   alu_zero     in   ALU result == 0, combinational from the datapath
//   sel_a/sel_b  out  operand select: 00 regA, 01 regB, 10 zero, 11 0xFF
//   alu_op       out  000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR
//   load_a/b     out  write the ALU result into regA/regB at this edge
//   busy         out  state != IDLE
//   done         out  1-cycle pulse in the final execute cycle
//   err          out  1-cycle pulse (with done) for an illegal opcode
//   flag_z       out  zero flag of the last writing instruction
//
// Build option: SEQ_PIPELINE_EN. When it is defined, the block also accepts an
// instruction in EXEC. Back-to-back instructions then run at one per cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an instruction; outputs at their reset values
// EXEC  | single execute cycle (also the third XOR step of SWAP); done=1
// SWAP1 | SWAP step 1: A <= A ^ B
// SWAP2 | SWAP step 2: B <= A ^ B
module alu_operand_sequencer (
    input  logic                         clk,
    input  logic                         rst_n,
    alu_operand_sequencer_if.slave       in_if,
    input  logic                         alu_zero,
    output logic [1:0]                   sel_a,
    output logic [1:0]                   sel_b,
    output logic [2:0]                   alu_op,
    output logic                         load_a,
    output logic                         load_b,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         flag_z
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SWAP1 = 2'd2,
        SWAP2 = 2'd3
    } state_t;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;
    localparam logic [1:0] SEL_ONES = 2'b11;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_MOV  = 4'h1;
    localparam logic [3:0] OPC_CLR  = 4'h2;
    localparam logic [3:0] OPC_SET  = 4'h3;
    localparam logic [3:0] OPC_ADD  = 4'h4;
    localparam logic [3:0] OPC_SUB  = 4'h5;
    localparam logic [3:0] OPC_AND  = 4'h6;
    localparam logic [3:0] OPC_OR   = 4'h7;
    localparam logic [3:0] OPC_XOR  = 4'h8;
    localparam logic [3:0] OPC_NOT  = 4'h9;
    localparam logic [3:0] OPC_DEC  = 4'hA;
    localparam logic [3:0] OPC_INC  = 4'hB;
    localparam logic [3:0] OPC_SWAP = 4'hC;

    state_t     state, state_nxt;
    logic [3:0] opc_q;
    logic       dst_q;
    logic       ready;
    logic       accept;
    logic       wr_dst;
    logic [1:0] sel_dst;
    logic [1:0] sel_oth;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^in_if.instr[2:0];

    // Only the state decides whether the block is ready. This means no instr
    // value can reach an output in the same cycle.
`ifdef SEQ_PIPELINE_EN
    assign ready = (state == IDLE) || (state == EXEC);
`else
    assign ready = (state == IDLE);
`endif

    assign in_if.instr_ready = ready;
    assign accept            = in_if.instr_valid & ready;
    assign busy              = (state != IDLE);

    // Operand codes for the destination register and the other register.
    assign sel_dst = dst_q ? SEL_B : SEL_A;
    assign sel_oth = dst_q ? SEL_A : SEL_B;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opc_q  <= OPC_NOP;
            dst_q  <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                opc_q <= in_if.instr[7:4];
                dst_q <= in_if.instr[3];
            end
            if (load_a | load_b) begin
                flag_z <= alu_zero;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sel_a     = SEL_ZERO;
        sel_b     = SEL_ZERO;
        alu_op    = OP_ADD;
        load_a    = 1'b0;
        load_b    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        wr_dst    = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (in_if.instr[7:4] == OPC_SWAP) ? SWAP1 : EXEC;
                end
            end

            SWAP1: begin
                sel_a     = SEL_A;
                sel_b     = SEL_B;
                alu_op    = OP_XOR;
                load_a    = 1'b1;
                state_nxt = SWAP2;
            end

            SWAP2: begin
                sel_a     = SEL_A;
                sel_b     = SEL_B;
                alu_op    = OP_XOR;
                load_b    = 1'b1;
                state_nxt = EXEC;
            end

            EXEC: begin
                done      = 1'b1;
                state_nxt = IDLE;
`ifdef SEQ_PIPELINE_EN
                if (accept) begin
                    state_nxt = (in_if.instr[7:4] == OPC_SWAP) ? SWAP1 : EXEC;
                end
`endif
                case (opc_q)
                    OPC_NOP: begin
                    end
                    OPC_MOV: begin
                        sel_a  = sel_oth;
                        sel_b  = SEL_ZERO;
                        wr_dst = 1'b1;
                    end
                    OPC_CLR: begin
                        wr_dst = 1'b1;
                    end
                    OPC_SET: begin
                        sel_a  = SEL_ONES;
                        wr_dst = 1'b1;
                    end
                    OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR: begin
                        sel_a  = SEL_A;
                        sel_b  = SEL_B;
                        wr_dst = 1'b1;
                        case (opc_q)
                            OPC_SUB: alu_op = OP_SUB;
                            OPC_AND: alu_op = OP_AND;
                            OPC_OR:  alu_op = OP_OR;
                            OPC_XOR: alu_op = OP_XOR;
                            default: alu_op = OP_ADD;
                        endcase
                    end
                    OPC_NOT: begin
                        sel_a  = sel_dst;
                        sel_b  = SEL_ONES;
                        alu_op = OP_XOR;
                        wr_dst = 1'b1;
                    end
                    OPC_DEC: begin
                        // D + 0xFF is D - 1 modulo 256.
                        sel_a  = sel_dst;
                        sel_b  = SEL_ONES;
                        alu_op = OP_ADD;
                        wr_dst = 1'b1;
                    end
                    OPC_INC: begin
                        // D - 0xFF is D + 1 modulo 256.
                        sel_a  = sel_dst;
                        sel_b  = SEL_ONES;
                        alu_op = OP_SUB;
                        wr_dst = 1'b1;
                    end
                    OPC_SWAP: begin
                        // This is the third XOR step of SWAP. It always writes A,
                        // whatever the dst bit is.
                        sel_a  = SEL_A;
                        sel_b  = SEL_B;
                        alu_op = OP_XOR;
                        load_a = 1'b1;
                    end
                    default: begin
                        err = 1'b1;
                    end
                endcase
                if (wr_dst) begin
                    load_a = ~dst_q;
                    load_b = dst_q;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
